// File: rtl/data_out_8_to_64_pkg.sv
// -----------------------------------------------------------------------------
// data_out_8_to_64_pkg
// Shared constants for the UART byte <-> 64-bit word converters (receive-side
// 8-to-64 assembler and transmit-side 64-to-8 splitter).
//   BYTES_PER_WORD / BYTE_W / WORD_W : word geometry, least-significant byte first
//   ST_IDLE / ST_COLLECT / ST_EMIT   : assembler FSM state encoding
// -----------------------------------------------------------------------------
package data_out_8_to_64_pkg;

  localparam int BYTES_PER_WORD = 8;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_EMIT    = 2'd2;

endpackage : data_out_8_to_64_pkg

// File: rtl/data_out_8_to_64_rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Registered rising-edge detector. The input is delayed by one flop and the
// strobe is high while the input is high and its delayed copy is still low,
// so a level held high for many cycles yields a single strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   sig_in     : level or pulse to watch
//   sig_q      : one-cycle delayed copy of sig_in (reset 0)
//   rise       : sig_in & ~sig_q
// -----------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_q,
  output logic rise
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_in;
    end
  end

  assign rise = sig_in & ~sig_q;

endmodule : rise_detect

// File: rtl/data_out_8_to_64.sv
// -----------------------------------------------------------------------------
// data_out_8_to_64
// Receive-side byte assembler: packs eight UART bytes (LSB first) into one
// 64-bit word, with an inter-byte timeout that discards stale partial words.
//   clk, rst_n    : clock, asynchronous active-low reset
//   data_8        : received byte, stable while rx_done is high
//   rx_done       : receiver done strobe; only its rising edge counts
//   clear         : synchronous flush of any partial word
//   data_64       : last completed word, held until the next completes
//   data_64_valid : one-cycle pulse when data_64 updates
//   byte_cnt      : bytes collected toward the current word (0..7)
//   timeout_err   : one-cycle pulse when a partial word is discarded
// -----------------------------------------------------------------------------
module data_out_8_to_64
  import data_out_8_to_64_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] data_8,
  input  logic              rx_done,
  input  logic              clear,
  output logic [WORD_W-1:0] data_64,
  output logic              data_64_valid,
  output logic [3:0]        byte_cnt,
  output logic              timeout_err
);

  localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]      LAST_BYTE = 4'(BYTES_PER_WORD - 1);

  logic              rx_done_1;
  logic              byte_stb;

  logic [1:0]        state_q,     state_d;
  logic [3:0]        byte_cnt_q,  byte_cnt_d;
  logic [WORD_W-1:0] shift_q,     shift_d;
  logic [WORD_W-1:0] data_64_q,   data_64_d;
  logic              valid_q,     valid_d;
  logic              tmo_err_q,   tmo_err_d;
  logic [CNT_W-1:0]  tmo_cnt_q,   tmo_cnt_d;

  rise_detect u_rise_detect (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (rx_done),
    .sig_q  (rx_done_1),
    .rise   (byte_stb)
  );

  // Priority: clear, then an accepted byte, then the timeout.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    data_64_d  = data_64_q;
    tmo_cnt_d  = tmo_cnt_q;
    valid_d    = 1'b0;
    tmo_err_d  = 1'b0;

    if (clear) begin
      state_d    = ST_IDLE;
      byte_cnt_d = '0;
      shift_d    = '0;
      tmo_cnt_d  = '0;
    end else if (byte_stb) begin
      tmo_cnt_d = '0;
      if (byte_cnt_q == LAST_BYTE) begin
        // Eighth byte bypasses the shift register straight into the output.
        data_64_d  = {data_8, shift_q[WORD_W-BYTE_W-1:0]};
        valid_d    = 1'b1;
        byte_cnt_d = '0;
        shift_d    = '0;
        state_d    = ST_EMIT;
      end else begin
        shift_d[{byte_cnt_q[2:0], 3'b000} +: BYTE_W] = data_8;
        byte_cnt_d = byte_cnt_q + 4'd1;
        state_d    = ST_COLLECT;
      end
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (tmo_cnt_q == TMO_MAX) begin
            state_d    = ST_IDLE;
            byte_cnt_d = '0;
            shift_d    = '0;
            tmo_cnt_d  = '0;
            tmo_err_d  = 1'b1;
          end else begin
            // Saturating: the compare above stops it at TMO_MAX.
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          end
        end
        ST_EMIT: begin
          state_d   = ST_IDLE;
          tmo_cnt_d = '0;
        end
        default: begin
          state_d   = ST_IDLE;
          tmo_cnt_d = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the shift register is a small register bank, not a
  // RAM, so it is safe (and required) to clear it on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      data_64_q  <= '0;
      valid_q    <= 1'b0;
      tmo_err_q  <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      data_64_q  <= data_64_d;
      valid_q    <= valid_d;
      tmo_err_q  <= tmo_err_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign data_64       = data_64_q;
  assign data_64_valid = valid_q;
  assign byte_cnt      = byte_cnt_q;
  assign timeout_err   = tmo_err_q;

endmodule : data_out_8_to_64

// File: tb/tb_data_out_8_to_64.sv
// -----------------------------------------------------------------------------
// tb_data_out_8_to_64
// Directed bench for the 8-to-64 byte assembler (TIMEOUT_CYCLES = 100).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_data_out_8_to_64;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_8;
  logic        rx_done;
  logic        clear;
  logic [63:0] data_64;
  logic        data_64_valid;
  logic [3:0]  byte_cnt;
  logic        timeout_err;

  int vectors     = 0;
  int miscompares = 0;
  int valid_seen  = 0;
  int err_seen    = 0;

  data_out_8_to_64 #(.TIMEOUT_CYCLES(100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_8        (data_8),
    .rx_done       (rx_done),
    .clear         (clear),
    .data_64       (data_64),
    .data_64_valid (data_64_valid),
    .byte_cnt      (byte_cnt),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled on the same edge as the checks.
  always @(negedge clk) begin
    if (data_64_valid) valid_seen++;
    if (timeout_err)   err_seen++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise rx_done for one cycle; returns on the falling edge right after the
  // rising edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b);
    data_8  = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Eight bytes LSB first, `gap` cycles apart (gap >= 2); returns right after
  // the last byte, where the valid pulse should be visible.
  task automatic send_word(input logic [63:0] w, input int gap);
    for (int i = 0; i < 8; i++) begin
      send_byte(w[8*i +: 8]);
      if (i != 7) idle(gap - 1);
    end
  endtask

  initial begin
    int k;
    rst_n   = 1'b0;
    data_8  = 8'h00;
    rx_done = 1'b0;
    clear   = 1'b0;

    // Reset state
    idle(2);
    check("rst_data_64", data_64, 64'h0);
    check("rst_valid",   64'(data_64_valid), 64'h0);
    check("rst_byte_cnt", 64'(byte_cnt), 64'h0);
    check("rst_err",     64'(timeout_err), 64'h0);
    rst_n = 1'b1;
    idle(2);

    // Bytes 0x01..0x08, 10 cycles apart
    send_byte(8'h01);
    check("w1_cnt_after_first", 64'(byte_cnt), 64'd1);
    idle(9);
    for (int i = 2; i <= 8; i++) begin
      send_byte(8'(i));
      if (i != 8) idle(9);
    end
    check("w1_valid",    64'(data_64_valid), 64'h1);
    check("w1_data",     data_64, 64'h0807060504030201);
    check("w1_cnt_zero", 64'(byte_cnt), 64'h0);
    idle(1);
    check("w1_valid_drop", 64'(data_64_valid), 64'h0);
    check("w1_data_hold",  data_64, 64'h0807060504030201);

    // rx_done held high for 20 cycles counts as one byte
    idle(3);
    data_8  = 8'hAA;
    rx_done = 1'b1;
    idle(20);
    rx_done = 1'b0;
    check("hold_cnt_once", 64'(byte_cnt), 64'd1);
    idle(2);
    for (int i = 1; i <= 7; i++) begin
      send_byte(8'hB0 + 8'(i));
      if (i != 7) idle(3);
    end
    check("hold_valid", 64'(data_64_valid), 64'h1);
    check("hold_data",  data_64, 64'hB7B6B5B4B3B2B1AA);
    idle(1);
    check("hold_pulses", 64'(valid_seen), 64'd2);

    // Timeout after three bytes: error 101 cycles after the accepting edge
    idle(3);
    send_byte(8'h21); idle(2);
    send_byte(8'h22); idle(2);
    send_byte(8'h23);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (timeout_err) begin
        k = i;
        break;
      end
    end
    check("tmo_delay",    64'(k), 64'd101);
    check("tmo_cnt_zero", 64'(byte_cnt), 64'h0);
    idle(1);
    check("tmo_err_drop", 64'(timeout_err), 64'h0);
    check("tmo_no_valid", 64'(valid_seen), 64'd2);
    send_word(64'h8877665544332211, 2);
    check("tmo_next_word", data_64, 64'h8877665544332211);
    check("tmo_next_valid", 64'(data_64_valid), 64'h1);
    idle(2);

    // Clear after five bytes
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h40 + 8'(i));
      idle(2);
    end
    check("clr_cnt_before", 64'(byte_cnt), 64'd5);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_cnt_zero",  64'(byte_cnt), 64'h0);
    check("clr_data_hold", data_64, 64'h8877665544332211);
    idle(2);
    check("clr_no_pulses", 64'(valid_seen * 16 + err_seen), 64'(3 * 16 + 1));
    // A byte strobe coincident with clear is dropped
    clear = 1'b1;
    send_byte(8'hEE);
    clear = 1'b0;
    check("clr_drops_byte", 64'(byte_cnt), 64'h0);
    idle(2);
    send_word(64'hDEADBEEFCAFEF00D, 3);
    check("clr_next_word", data_64, 64'hDEADBEEFCAFEF00D);
    idle(2);

    // Asynchronous reset mid-word
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h90 + 8'(i));
      idle(2);
    end
    check("arst_cnt_before", 64'(byte_cnt), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data_64",  data_64, 64'h0);
    check("arst_byte_cnt", 64'(byte_cnt), 64'h0);
    check("arst_valid_err", 64'({data_64_valid, timeout_err}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_word(64'h0123456789ABCDEF, 2);
    check("arst_next_word", data_64, 64'h0123456789ABCDEF);
    idle(2);

    // Byte strobe aligned with the cycle the counter reaches TIMEOUT_CYCLES
    send_byte(8'h55);
    idle(100);
    send_byte(8'h66);
    check("align_cnt_inc", 64'(byte_cnt), 64'd2);
    check("align_no_err",  64'(err_seen), 64'd1);
    idle(2);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'h77 + 8'(i * 17));
      if (i != 5) idle(2);
    end
    check("align_word", data_64, 64'hCCBBAA9988776655);
    idle(2);
    check("total_valid", 64'(valid_seen), 64'd6);
    check("total_err",   64'(err_seen), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_data_out_8_to_64

// File: doc/data_out_8_to_64.md
# data_out_8_to_64

Receive-side byte assembler that converts the UART receiver's 8-bit output stream back into 64-bit parallel words. Bytes arrive least-significant first, matching the order used by the transmit-side 64-to-8 splitter. Each byte is qualified by a rising edge on the receiver's done strobe; after eight bytes the block presents one 64-bit word with a single-cycle valid pulse. An inter-byte timeout discards stale partial words so the link resynchronises after a dropped byte.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 50000: clock cycles allowed between accepted bytes of one word; legal range ≥ 2.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- data_8  input  8  byte from UART receiver; stable while rx_done is high.
- rx_done  input  1  receiver byte-done strobe; level or pulse; only its rising edge is significant.
- clear  input  1  synchronous flush of any partial word; active high.
- data_64  output  64  last completed word; holds until the next word completes.
- data_64_valid  output  1  one-cycle pulse when data_64 updates.
- byte_cnt  output  4  bytes collected toward the current word, 0..7.
- timeout_err  output  1  one-cycle pulse when a partial word is discarded by timeout.

## Operation
- Edge detect: register rx_done into rx_done_1 (reset 0). Define byte_stb = rx_done & ~rx_done_1.
- Byte order: the byte accepted with byte_cnt = k goes to bits [8k+7:8k]. The first byte fills [7:0]; the eighth fills [63:56].
- States:
  - IDLE: byte_cnt = 0, timeout counter stopped. On byte_stb: store byte 0, go to COLLECT with byte_cnt = 1.
  - COLLECT: on byte_stb, store byte k and increment byte_cnt. When the eighth byte arrives (byte_cnt = 7): load data_64 with the full word including that byte, set data_64_valid, reset byte_cnt to 0, and go to EMIT. If the timeout counter reaches TIMEOUT_CYCLES with no byte_stb: clear byte_cnt and the shift register, pulse timeout_err, and go to IDLE.
  - EMIT: lasts one cycle with data_64_valid = 1, then returns to IDLE. A byte_stb during EMIT is accepted as byte 0 of the next word and moves to COLLECT.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1). Cleared on every accepted byte. Increments each cycle in COLLECT and saturates; it never wraps.
- Priority, highest first: rst_n, then clear, then byte_stb, then timeout.
  - clear: forces IDLE, byte_cnt = 0, shift register = 0, and no valid or err pulse. data_64 keeps its last value. A byte_stb in the same cycle is dropped.
  - byte_stb and timeout in the same cycle: the byte is accepted, no timeout_err, and the counter restarts.
- rx_done held high across many cycles produces exactly one byte.

## Timing
- Reset values, all asynchronous: data_64 = 0, data_64_valid = 0, byte_cnt = 0, timeout_err = 0, state = IDLE, shift register = 0, rx_done_1 = 0, timeout counter = 0.
- Byte acceptance:
  - In cycle t, rx_done = 1 and rx_done_1 = 0, so byte_stb is high.
  - data_8 is sampled at the clock edge that ends cycle t.
  - byte_cnt shows the new count in cycle t+1.
- Word latency: for the eighth byte's byte_stb in cycle t, data_64 and data_64_valid = 1 are visible in cycle t+1. data_64_valid is low again in t+2.
- Throughput: the minimum byte spacing is 2 cycles, set by the edge detector. Back-to-back words need no idle gap.
- timeout_err: high for exactly one cycle, namely the cycle after the counter reaches TIMEOUT_CYCLES. byte_cnt reads 0 in that same cycle.
- Reset asserted mid-word: all state clears immediately. After release, collection restarts at byte 0.

## Structure
- Shared package / header:
  - BYTES_PER_WORD = 8 and BYTE_W = 8, also used by the transmit-side splitter.
  - State encoding IDLE / COLLECT / EMIT.
- One natural sub-module: rise_detect (registered rising-edge detector with async active-low reset). The transmit side can reuse it for its own strobe edges.
- The remaining logic (shift register, counters, FSM) is flat in this module.

## Test plan
- After reset, send bytes 0x01..0x08 spaced 10 cycles apart. Expect data_64 = 0x0807060504030201 with data_64_valid high for exactly one cycle, one cycle after the 8th strobe; byte_cnt returns to 0.
- Hold rx_done high for 20 cycles carrying 0xAA, then send 7 further bytes. Expect 0xAA counted once, and exactly one word with 0xAA in [7:0].
- With TIMEOUT_CYCLES = 100, send 3 bytes and then idle. Expect timeout_err to pulse 101 cycles after the last strobe and byte_cnt = 0. Then send 8 bytes 0x11..0x88; expect data_64 = 0x8877665544332211.
- Send 5 bytes, then assert clear for 1 cycle. Expect byte_cnt = 0, no valid or err pulse, and data_64 unchanged. The next 8 bytes form a clean word.
- Pull rst_n low mid-word (byte_cnt = 4). Expect all outputs 0 immediately, without waiting for a clock edge; after release, 8 bytes yield the correct word.
- Align a byte_stb with the cycle in which the counter reaches TIMEOUT_CYCLES. Expect the byte accepted, no timeout_err, and byte_cnt incremented.
